// File: rtl/bju_hazard_ctrl_if.sv
// Signal bundle between the decode-stage branch/jump unit, the pipeline
// stage registers and the hazard controller.
interface bju_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             valid_D;
   logic [2:0]       branch_D;
   logic             jump_D;
   logic             jump_type_D;
   logic [4:0]       rs1_D;
   logic [4:0]       rs2_D;
   logic [4:0]       rd_E;
   logic             reg_write_E;
   logic             mem_read_E;
   logic [4:0]       rd_M;
   logic             reg_write_M;
   logic             mem_read_M;
   logic [4:0]       rd_W;
   logic             reg_write_W;
   logic             PC_src_D;
   logic             perf_clr;
   logic [1:0]       forward_A_D;
   logic [1:0]       forward_B_D;
   logic             stall_F;
   logic             stall_D;
   logic             flush_D;
   logic             flush_E;
   logic [CNT_W-1:0] br_cnt;
   logic [CNT_W-1:0] taken_cnt;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output valid_D, branch_D, jump_D, jump_type_D, rs1_D, rs2_D,
      output rd_E, reg_write_E, mem_read_E, rd_M, reg_write_M, mem_read_M,
      output rd_W, reg_write_W, PC_src_D, perf_clr,
      input  forward_A_D, forward_B_D, stall_F, stall_D, flush_D, flush_E,
      input  br_cnt, taken_cnt, stall_cnt
   );

   modport slave (
      input  valid_D, branch_D, jump_D, jump_type_D, rs1_D, rs2_D,
      input  rd_E, reg_write_E, mem_read_E, rd_M, reg_write_M, mem_read_M,
      input  rd_W, reg_write_W, PC_src_D, perf_clr,
      output forward_A_D, forward_B_D, stall_F, stall_D, flush_D, flush_E,
      output br_cnt, taken_cnt, stall_cnt
   );
endinterface

// File: rtl/bju_hazard_ctrl.sv
// Decode-stage branch/jump hazard controller: operand forwarding selects,
// load-use stall sequencing, redirect flush and saturating statistics.
module bju_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   bju_hazard_ctrl_if.slave  bus
);

   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   logic [0:0] state_reg;
   logic [0:0] state_next;
   logic       ctrl_d;
   logic       use1;
   logic       use2;
   logic       hz_e;
   logic       hz_m;
   logic       stall;
   logic [2:0] inc;

   // Loads are never forwarded from E or M: their data only exists from W on.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] rd_e, input logic rw_e, input logic mr_e,
      input logic [4:0] rd_m, input logic rw_m, input logic mr_m,
      input logic [4:0] rd_w, input logic rw_w
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (rs != 5'd0) begin
         if (rw_e && !mr_e && rd_e == rs)
            sel = 2'b01;
         else if (rw_m && !mr_m && rd_m == rs)
            sel = 2'b10;
         else if (rw_w && rd_w == rs)
            sel = 2'b11;
      end
      return sel;
   endfunction

   assign bus.forward_A_D = fwd_sel(bus.rs1_D,
                                    bus.rd_E, bus.reg_write_E, bus.mem_read_E,
                                    bus.rd_M, bus.reg_write_M, bus.mem_read_M,
                                    bus.rd_W, bus.reg_write_W);
   assign bus.forward_B_D = fwd_sel(bus.rs2_D,
                                    bus.rd_E, bus.reg_write_E, bus.mem_read_E,
                                    bus.rd_M, bus.reg_write_M, bus.mem_read_M,
                                    bus.rd_W, bus.reg_write_W);

   assign ctrl_d = bus.valid_D & (bus.jump_D | (bus.branch_D != 3'b010));
   assign use1   = ctrl_d & ~(bus.jump_D & bus.jump_type_D);
   assign use2   = ctrl_d & ~bus.jump_D;

   assign hz_e = ((use1 & (bus.rs1_D == bus.rd_E)) | (use2 & (bus.rs2_D == bus.rd_E)))
               & bus.mem_read_E & bus.reg_write_E & (bus.rd_E != 5'd0);
   assign hz_m = ((use1 & (bus.rs1_D == bus.rd_M)) | (use2 & (bus.rs2_D == bus.rd_M)))
               & bus.mem_read_M & bus.reg_write_M & (bus.rd_M != 5'd0);

   // A load in E needs a second stall cycle while it crosses M; HOLD covers it.
   always_comb begin
      state_next = RUN;
      case (state_reg)
         RUN:     state_next = hz_e ? HOLD : RUN;
         HOLD:    state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= RUN;
      else
         state_reg <= state_next;
   end

   assign stall = ~rst & ((state_reg == HOLD) | hz_e | hz_m);

   assign bus.stall_F = stall;
   assign bus.stall_D = stall;
   assign bus.flush_E = stall;
   // A redirect computed from stale operands during a stall must not flush.
   assign bus.flush_D = ~rst & bus.PC_src_D & ~stall;

   assign inc[0] = ctrl_d & ~stall;
   assign inc[1] = bus.PC_src_D & ctrl_d & ~stall;
   assign inc[2] = stall;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               cnt_reg <= '0;
            else if (bus.perf_clr)
               cnt_reg <= '0;
            else if (inc[gi] && (cnt_reg != {CNT_W{1'b1}}))
               cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   endgenerate

   assign bus.br_cnt    = g_cnt[0].cnt_reg;
   assign bus.taken_cnt = g_cnt[1].cnt_reg;
   assign bus.stall_cnt = g_cnt[2].cnt_reg;

endmodule
